// File: rtl/ah_grant_hold_8_if.sv
// ah_grant_hold_8_if: grant, per-requester beat and downstream channel bundle for the grant-hold controller
interface ah_grant_hold_8_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 4
);
  logic [7:0] gnt_in;
  logic [8*LEN_W-1:0] len;
  logic [7:0] src_valid;
  logic [8*DATA_W-1:0] src_data;
  logic [7:0] src_ready;
  logic dst_valid;
  logic [DATA_W-1:0] dst_data;
  logic dst_last;
  logic [2:0] dst_id;
  logic dst_ready;
  logic [7:0] gnt_busy;
  logic timeout_err;
  logic multi_gnt_err;
  modport master (
    output gnt_in, len, src_valid, src_data, dst_ready,
    input src_ready, dst_valid, dst_data, dst_last, dst_id, gnt_busy, timeout_err, multi_gnt_err
  );
  modport slave (
    input gnt_in, len, src_valid, src_data, dst_ready,
    output src_ready, dst_valid, dst_data, dst_last, dst_id, gnt_busy, timeout_err, multi_gnt_err
  );
endinterface

// File: rtl/ah_grant_hold_8.sv
// ah_grant_hold_8: latches an arbiter grant and streams the owner's burst onto one downstream channel
module ah_grant_hold_8 #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  ah_grant_hold_8_if.slave bus
);
  localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOCK, RELEASE} state_t;
  state_t state;
  logic [2:0] owner, low;
  logic [LEN_W-1:0] cnt;
  logic [IW-1:0] idle;
  logic lock, xfer, to_hit;
  // lowest set grant bit picks the owner when the grant is not one-hot
  always_comb begin
    low = '0;
    for (int i = 7; i >= 0; i--) if (bus.gnt_in[i]) low = 3'(i);
  end
  assign lock = state == LOCK;
  assign xfer = bus.dst_valid & bus.dst_ready;
  assign to_hit = (TIMEOUT > 0) && (idle + IW'(1) == IW'(TIMEOUT));
  assign bus.dst_valid = lock & bus.src_valid[owner];
  assign bus.dst_data = bus.src_data[owner*DATA_W +: DATA_W];
  assign bus.src_ready = lock ? (8'(bus.dst_ready) << owner) : 8'h00;
  assign bus.dst_last = lock & (cnt == '0);
  assign bus.dst_id = owner;
  assign bus.gnt_busy = {8{state != IDLE}};
  // grant latch, beat countdown, idle watchdog and error pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      cnt <= '0;
      idle <= '0;
      bus.timeout_err <= 1'b0;
      bus.multi_gnt_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      bus.multi_gnt_err <= 1'b0;
      case (state)
        IDLE: if (|bus.gnt_in) begin
          owner <= low;
          cnt <= bus.len[low*LEN_W +: LEN_W];
          idle <= '0;
          state <= LOCK;
          bus.multi_gnt_err <= |(bus.gnt_in & (bus.gnt_in - 8'd1));
        end
        LOCK: if (xfer) begin
          idle <= '0;
          if (cnt == '0) state <= RELEASE;
          else cnt <= cnt - LEN_W'(1);
        end else if (to_hit) begin
          bus.timeout_err <= 1'b1;
          state <= RELEASE;
        end else if (idle != '1) idle <= idle + IW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ah_grant_hold_8.sv
// tb_ah_grant_hold_8: randomized burst scenarios checked against a transaction-level model
module tb_ah_grant_hold_8;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  ah_grant_hold_8_if #(.DATA_W(DW), .LEN_W(LW)) b ();
  ah_grant_hold_8 #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;

  task automatic rand_data();
    for (int i = 0; i < 8; i++) b.src_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic rand_len();
    for (int i = 0; i < 8; i++) b.len[i*LW +: LW] = LW'($urandom);
  endtask

  task automatic clear_inputs();
    b.gnt_in = '0;
    b.len = '0;
    b.src_valid = '0;
    b.src_data = '0;
    b.dst_ready = 1'b0;
  endtask

  // one complete grant: grant cycle, LOCK cycles, RELEASE, back in IDLE
  task automatic run_burst(input logic [7:0] g, input int flen, input int pv, input int pr,
                           input int hold, input bit disturb, output int obs_x, output bit obs_to);
    int own, beats, done, idle, cyc;
    bit fin, to, multi;
    logic [7:0] exp_rdy;
    logic exp_last;
    own = 0;
    for (int i = 7; i >= 0; i--) if (g[i]) own = i;
    multi = $countones(g) > 1;
    obs_x = 0;
    @(posedge clk); #1;
    b.gnt_in = g;
    rand_len();
    if (flen >= 0) b.len[own*LW +: LW] = LW'(flen);
    beats = int'(b.len[own*LW +: LW]) + 1;
    b.src_valid = 8'($urandom);
    b.dst_ready = 1'($urandom);
    rand_data();
    @(negedge clk);
    n_checks++;
    if ({b.gnt_busy, b.dst_valid, b.src_ready} !== 17'h0) begin
      n_fail++;
      $display("FAIL grant_cycle: busy/valid/ready got %h/%b/%h want 00/0/00", b.gnt_busy, b.dst_valid, b.src_ready);
    end
    done = 0; idle = 0; to = 0; fin = 0; cyc = 0;
    while (!fin) begin
      @(posedge clk); #1;
      b.gnt_in = disturb ? 8'($urandom) : 8'h00;
      if (disturb) rand_len();
      b.src_valid = 8'($urandom);
      b.src_valid[own] = (cyc >= hold) && ($urandom_range(99) < pv);
      b.dst_ready = $urandom_range(99) < pr;
      rand_data();
      @(negedge clk);
      exp_rdy = 8'(b.dst_ready) << own;
      exp_last = done == beats - 1;
      n_checks++;
      if ({b.gnt_busy, b.dst_id, b.dst_valid, b.dst_last, b.src_ready} !== {8'hFF, 3'(own), b.src_valid[own], exp_last, exp_rdy}) begin
        n_fail++;
        $display("FAIL lock_ctrl cyc %0d: busy/id/valid/last/ready got %h/%0d/%b/%b/%h want ff/%0d/%b/%b/%h",
                 cyc, b.gnt_busy, b.dst_id, b.dst_valid, b.dst_last, b.src_ready, own, b.src_valid[own], exp_last, exp_rdy);
      end
      n_checks++;
      if (b.dst_data !== b.src_data[own*DW +: DW]) begin
        n_fail++;
        $display("FAIL lock_data cyc %0d: got %h want %h", cyc, b.dst_data, b.src_data[own*DW +: DW]);
      end
      n_checks++;
      if ({b.timeout_err, b.multi_gnt_err} !== {1'b0, cyc == 0 && multi}) begin
        n_fail++;
        $display("FAIL lock_err cyc %0d: to/multi got %b%b want 0%b", cyc, b.timeout_err, b.multi_gnt_err, cyc == 0 && multi);
      end
      if (b.dst_valid === 1'b1 && b.dst_ready) obs_x++;
      if (b.src_valid[own] && b.dst_ready) begin
        done++;
        idle = 0;
        fin = done == beats;
      end else begin
        idle++;
        if (idle == TO) begin to = 1; fin = 1; end
      end
      cyc++;
      if (cyc > 4000) begin
        n_fail++;
        $display("FAIL burst_bound: model exceeded cycle budget");
        fin = 1;
      end
    end
    @(posedge clk); #1;
    b.gnt_in = disturb ? (8'($urandom) | 8'h01) : 8'h00;
    b.src_valid = 8'hFF;
    b.dst_ready = 1'b1;
    @(negedge clk);
    obs_to = b.timeout_err;
    n_checks++;
    if ({b.gnt_busy, b.dst_valid, b.src_ready, b.timeout_err, b.multi_gnt_err} !== {8'hFF, 1'b0, 8'h00, to, 1'b0}) begin
      n_fail++;
      $display("FAIL release: busy/valid/ready/to/multi got %h/%b/%h/%b/%b want ff/0/00/%b/0",
               b.gnt_busy, b.dst_valid, b.src_ready, b.timeout_err, b.multi_gnt_err, to);
    end
    @(posedge clk); #1;
    b.gnt_in = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({b.gnt_busy, b.dst_valid, b.src_ready, b.timeout_err, b.dst_id} !== {8'h00, 1'b0, 8'h00, 1'b0, 3'(own)}) begin
      n_fail++;
      $display("FAIL back_idle: busy/valid/ready/to/id got %h/%b/%h/%b/%0d want 00/0/00/0/%0d",
               b.gnt_busy, b.dst_valid, b.src_ready, b.timeout_err, b.dst_id, own);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({b.gnt_busy, b.dst_valid, b.dst_last, b.dst_id, b.src_ready, b.timeout_err, b.multi_gnt_err} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset: outputs got %h/%b/%b/%0d/%h/%b/%b want all zero",
               b.gnt_busy, b.dst_valid, b.dst_last, b.dst_id, b.src_ready, b.timeout_err, b.multi_gnt_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic expect_run(input string name, input int got_x, input int want_x, input bit got_to, input bit want_to);
    n_checks++;
    if (got_x !== want_x || got_to !== want_to) begin
      n_fail++;
      $display("FAIL %s: transfers/timeout got %0d/%b want %0d/%b", name, got_x, got_to, want_x, want_to);
    end
  endtask

  task automatic test_basic();
    int x; bit t;
    run_burst(8'h04, 3, 100, 100, 0, 0, x, t);
    expect_run("basic_burst", x, 4, t, 0);
  endtask

  task automatic test_ready_toggle();
    int x; bit t;
    run_burst(8'h04, 3, 100, 50, 0, 0, x, t);
    expect_run("ready_toggle", x, 4, t, 0);
  endtask

  task automatic test_timeout();
    int x; bit t;
    run_burst(8'h01, 0, 0, 100, 0, 0, x, t);
    expect_run("timeout", x, 0, t, 1);
    run_burst(8'h01, 0, 100, 100, TO - 1, 0, x, t);
    expect_run("timeout_race", x, 1, t, 0);
    run_burst(8'h02, 2, 100, 100, TO, 0, x, t);
    expect_run("timeout_edge", x, 0, t, 1);
  endtask

  task automatic test_multi_grant();
    int x; bit t;
    run_burst(8'h28, 5, 100, 100, 0, 0, x, t);
    expect_run("multi_grant", x, 6, t, 0);
  endtask

  task automatic test_hold();
    int x; bit t;
    run_burst(8'h20, 15, 70, 70, 0, 1, x, t);
    expect_run("hold_16", x, 16, t, 0);
  endtask

  task automatic test_back_to_back();
    int x; bit t;
    for (int k = 0; k < 20; k++)
      run_burst(8'($urandom_range(1, 255)), -1, $urandom_range(50, 100), $urandom_range(50, 100), 0, 1'($urandom), x, t);
  endtask

  task automatic test_reset_mid_burst();
    int x; bit t;
    @(posedge clk); #1;
    b.gnt_in = 8'h04;
    b.len = '0;
    b.len[2*LW +: LW] = LW'(3);
    b.src_valid = 8'h04;
    b.dst_ready = 1'b1;
    @(posedge clk); #1;
    b.gnt_in = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({b.gnt_busy, b.dst_id, b.dst_valid, b.dst_last} !== {8'hFF, 3'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_reset_beat2: busy/id/valid/last got %h/%0d/%b/%b want ff/2/1/0", b.gnt_busy, b.dst_id, b.dst_valid, b.dst_last);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b.gnt_busy, b.dst_valid, b.dst_last, b.dst_id, b.src_ready, b.timeout_err, b.multi_gnt_err} !== 23'h0) begin
      n_fail++;
      $display("FAIL mid_reset: outputs got %h/%b/%b/%0d/%h/%b/%b want all zero",
               b.gnt_busy, b.dst_valid, b.dst_last, b.dst_id, b.src_ready, b.timeout_err, b.multi_gnt_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    b.src_valid = 8'h00;
    run_burst(8'h04, 3, 100, 100, 0, 0, x, t);
    expect_run("post_reset_burst", x, 4, t, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_timeout();
    test_multi_grant();
    test_hold();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
